// File: rtl/ibuffer_shift_buffer.sv
// ibuffer_shift_buffer
// ---------------------------------------------------------------------------
// Two-row, 16-entry instruction parcel buffer between the fetch unit and the
// ibuffer dequeuer. Row0 (entries 0-7) is the oldest. Row1 (entries 8-15) is
// the youngest. When row0 has no valid entries left, row1 moves down into
// row0. A new fetch line is written into the lowest row that is empty after
// that shift.
//
// Optional feature macro: IBUFFER_EARLY_READY_EN
//   defined   : fetch_ready also rises in a cycle whose dequeue drains row0.
//               This adds a combinational path from deq_fire/deqing_vec to
//               fetch_ready.
//   undefined : fetch_ready = row1 empty. It is a pure register decode.
//
// Ports
//   CLK, nRST              clock, asynchronous active-low reset
//   fetch_valid            fetch line offered this cycle
//   fetch_valid_vec[8]     per-parcel valid of the offered line
//   fetch_uncompressed_vec first half of a 32-bit instruction, per parcel
//   fetch_redirect_vec     parcel ends a predicted redirect, per parcel
//   fetch_parcels          8 parcels, lane k at [k*PARCEL_WIDTH +: PARCEL_WIDTH]
//   fetch_ready            the line is accepted if fetch_valid
//   deq_fire, deqing_vec   entries consumed this cycle
//   flush                  discard all contents
//   valid_vec, uncompressed_vec, redirect_vec, parcel_vec
//                          registered per-entry state presented to the dequeuer
// ---------------------------------------------------------------------------
module ibuffer_shift_buffer #(
    parameter int PARCEL_WIDTH = 16
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       fetch_valid,
    input  logic [7:0]                 fetch_valid_vec,
    input  logic [7:0]                 fetch_uncompressed_vec,
    input  logic [7:0]                 fetch_redirect_vec,
    input  logic [8*PARCEL_WIDTH-1:0]  fetch_parcels,
    output logic                       fetch_ready,
    input  logic                       deq_fire,
    input  logic [15:0]                deqing_vec,
    input  logic                       flush,
    output logic [15:0]                valid_vec,
    output logic [15:0]                uncompressed_vec,
    output logic [15:0]                redirect_vec,
    output logic [16*PARCEL_WIDTH-1:0] parcel_vec
);

    logic [15:0]             valid_q, unc_q, redir_q;
    logic [PARCEL_WIDTH-1:0] data_q [16];

    logic [15:0]             valid_n, unc_n, redir_n;
    logic [PARCEL_WIDTH-1:0] data_n [16];

    logic [15:0] valid_deq;
    logic        shift_row;
    logic        enq_row1;
    logic        accept;

`ifdef IBUFFER_EARLY_READY_EN
    // Row1 frees up when this cycle's dequeue empties row0, because row1
    // moves down on the same edge.
    assign fetch_ready = ~|valid_q[15:8]
                       | (deq_fire & ((valid_q[7:0] & ~deqing_vec[7:0]) == 8'h00));
`else
    assign fetch_ready = ~|valid_q[15:8];
`endif

    assign accept = fetch_valid & fetch_ready;

    // Next state is computed as dequeue, then row shift, then enqueue, then
    // flush. Flush overrides the other three steps.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through this block leaves a latch.
        valid_deq = deq_fire ? (valid_q & ~deqing_vec) : valid_q;
        shift_row = (valid_deq[7:0] == 8'h00);
        valid_n   = valid_deq;
        unc_n     = unc_q;
        redir_n   = redir_q;
        data_n    = data_q;
        enq_row1  = 1'b0;

        if (shift_row) begin
            for (int i = 0; i < 8; i++) begin
                valid_n[i] = valid_deq[i+8];
                unc_n[i]   = unc_q[i+8];
                redir_n[i] = redir_q[i+8];
                data_n[i]  = data_q[i+8];
            end
            valid_n[15:8] = 8'h00;
        end

        // The line goes to row1 only when row0 still holds something after
        // the shift.
        enq_row1 = |valid_n[7:0];

        if (accept) begin
            for (int k = 0; k < 8; k++) begin
                if (enq_row1) begin
                    valid_n[k+8] = fetch_valid_vec[k];
                    unc_n[k+8]   = fetch_uncompressed_vec[k];
                    redir_n[k+8] = fetch_redirect_vec[k];
                    data_n[k+8]  = fetch_parcels[k*PARCEL_WIDTH +: PARCEL_WIDTH];
                end else begin
                    valid_n[k]   = fetch_valid_vec[k];
                    unc_n[k]     = fetch_uncompressed_vec[k];
                    redir_n[k]   = fetch_redirect_vec[k];
                    data_n[k]    = fetch_parcels[k*PARCEL_WIDTH +: PARCEL_WIDTH];
                end
            end
        end

        if (flush) begin
            valid_n = 16'h0000;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
            unc_q   <= '0;
            redir_q <= '0;
            // NOTE: the parcel storage is reset as well, because parcel_vec must read zero out of reset.
            for (int i = 0; i < 16; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            // NOTE: use non-blocking assignments for all state, so every register samples the pre-edge values.
            valid_q <= valid_n;
            unc_q   <= unc_n;
            redir_q <= redir_n;
            data_q  <= data_n;
        end
    end

    assign valid_vec        = valid_q;
    assign uncompressed_vec = unc_q;
    assign redirect_vec     = redir_q;

    always_comb begin
        parcel_vec = '0;
        for (int i = 0; i < 16; i++) begin
            parcel_vec[i*PARCEL_WIDTH +: PARCEL_WIDTH] = data_q[i];
        end
    end

endmodule
